// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file: two combinational read ports, ALU (A) and load (B)
// write ports, optional same-cycle write bypass, and a per-register busy bit for pending loads.
module regfile_mp_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we_a,
  input  logic [AW-1:0]   wa_a,
  input  logic [XLEN-1:0] wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  input  logic [XLEN-1:0] wd_b,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  // Port A is applied after port B so it wins an address conflict, while the
  // port B busy clear still happens; a new load issue is applied last so it
  // survives a retire to the same register on the same edge.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we_b) begin
      regs_d[wa_b] = wd_b;
      busy_d[wa_b] = 1'b0;
    end
    if (we_a) begin
      regs_d[wa_a] = wd_a;
    end
    if (busy_set) begin
      busy_d[busy_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Returns {busy, data}; busy_set deliberately never feeds this path.
  function automatic logic [XLEN:0] read_port(input logic [AW-1:0] ra);
    logic [XLEN-1:0] d;
    logic            b;
    d = regs_q[ra];
    b = busy_q[ra];
    if (BYPASS != 0) begin
      if (we_b && (wa_b == ra)) begin
        d = wd_b;
        b = 1'b0;
      end
      if (we_a && (wa_a == ra)) begin
        d = wd_a;
      end
    end
    if ((ZERO_REG != 0) && (ra == '0)) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  always_comb begin
    {busy1, rd1} = read_port(ra1);
    {busy2, rd2} = read_port(ra2);
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: a bypassed and a non-bypassed 32x32 instance share stimulus,
// plus a 64-bit, 16-entry instance without a hardwired zero register.
module tb_regfile_mp_scoreboard;

  logic clk;
  logic rst_n;

  logic [4:0]  ra1, ra2, wa_a, wa_b, busy_addr;
  logic        we_a, we_b, busy_set;
  logic [31:0] wd_a, wd_b;
  logic [31:0] rd1, rd2, n_rd1, n_rd2;
  logic        busy1, busy2, n_busy1, n_busy2;

  logic [3:0]  w_ra1, w_ra2, w_wa_a, w_wa_b, w_baddr;
  logic        w_we_a, w_we_b, w_bset;
  logic [63:0] w_wd_a, w_wd_b, w_rd1, w_rd2;
  logic        w_busy1, w_busy2;

  regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .busy_set(busy_set), .busy_addr(busy_addr)
  );

  regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2),
    .busy1(n_busy1), .busy2(n_busy2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .busy_set(busy_set), .busy_addr(busy_addr)
  );

  regfile_mp_scoreboard #(.XLEN(64), .NREGS(16), .ZERO_REG(0), .BYPASS(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .ra1(w_ra1), .ra2(w_ra2), .rd1(w_rd1), .rd2(w_rd2),
    .busy1(w_busy1), .busy2(w_busy2), .we_a(w_we_a), .wa_a(w_wa_a), .wd_a(w_wd_a),
    .we_b(w_we_b), .wa_b(w_wa_b), .wd_b(w_wd_b), .busy_set(w_bset), .busy_addr(w_baddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        bset;
    logic [4:0]  baddr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic        e_b1;
    logic [31:0] e_rd2;
    logic        e_b2;
    logic [31:0] n_rd1;
    logic        n_b1;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  exp_t sb_q [$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(
    input logic wea, input logic [4:0] waa, input logic [31:0] wda,
    input logic web, input logic [4:0] wab, input logic [31:0] wdb,
    input logic bs, input logic [4:0] ba, input logic [4:0] r1, input logic [4:0] r2,
    input logic [31:0] er1, input logic eb1, input logic [31:0] er2, input logic eb2,
    input logic [31:0] nr1, input logic nb1);
    vec_t v;
    v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
    v.we_b = web; v.wa_b = wab; v.wd_b = wdb;
    v.bset = bs;  v.baddr = ba; v.ra1 = r1;   v.ra2 = r2;
    v.e_rd1 = er1; v.e_b1 = eb1; v.e_rd2 = er2; v.e_b2 = eb2;
    v.n_rd1 = nr1; v.n_b1 = nb1;
    return v;
  endfunction

  task automatic push(input string n, input logic [63:0] e);
    exp_t t;
    t.name = n;
    t.exp  = e;
    sb_q.push_back(t);
  endtask

  task automatic pop_cmp(input logic [63:0] act);
    exp_t t;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h with no expected value queued", act);
    end else begin
      t = sb_q.pop_front();
      if (act !== t.exp) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", t.name, act, t.exp);
      end
    end
  endtask

  task automatic idle32();
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
    busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic idle64();
    w_we_a = 1'b0; w_wa_a = '0; w_wd_a = '0;
    w_we_b = 1'b0; w_wa_b = '0; w_wd_b = '0;
    w_bset = 1'b0; w_baddr = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ra1 = '0; ra2 = '0;
    w_ra1 = '0; w_ra2 = '0;
    idle32();
    idle64();

    //            we_a wa_a wd_a          we_b wa_b wd_b          bs ba  ra1 ra2  e_rd1         eb1 e_rd2         eb2 n_rd1         nb1
    vecs[0]  = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  0,  0,   32'h0,        0,  32'h0,        0,  32'h0,        0);
    vecs[1]  = mk(1,   7,   32'h12345678, 0,   0,   32'h0,        0, 0,  7,  7,   32'h12345678, 0,  32'h12345678, 0,  32'h0,        0);
    vecs[2]  = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  7,  7,   32'h12345678, 0,  32'h12345678, 0,  32'h12345678, 0);
    vecs[3]  = mk(1,   0,   32'hFFFFFFFF, 0,   0,   32'h0,        0, 0,  0,  0,   32'h0,        0,  32'h0,        0,  32'h0,        0);
    vecs[4]  = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  0,  7,   32'h0,        0,  32'h12345678, 0,  32'h0,        0);
    vecs[5]  = mk(0,   0,   32'h0,        0,   0,   32'h0,        1, 4,  4,  4,   32'h0,        0,  32'h0,        0,  32'h0,        0);
    vecs[6]  = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  4,  4,   32'h0,        1,  32'h0,        1,  32'h0,        1);
    vecs[7]  = mk(0,   0,   32'h0,        1,   3,   32'hCAFEF00D, 0, 0,  4,  3,   32'h0,        1,  32'hCAFEF00D, 0,  32'h0,        1);
    vecs[8]  = mk(0,   0,   32'h0,        1,   4,   32'hAAAA5555, 0, 0,  4,  3,   32'hAAAA5555, 0,  32'hCAFEF00D, 0,  32'h0,        1);
    vecs[9]  = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  4,  3,   32'hAAAA5555, 0,  32'hCAFEF00D, 0,  32'hAAAA5555, 0);
    vecs[10] = mk(0,   0,   32'h0,        0,   0,   32'h0,        1, 9,  9,  9,   32'h0,        0,  32'h0,        0,  32'h0,        0);
    vecs[11] = mk(1,   9,   32'h1,        1,   9,   32'h2,        0, 0,  9,  9,   32'h1,        0,  32'h1,        0,  32'h0,        1);
    vecs[12] = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  9,  9,   32'h1,        0,  32'h1,        0,  32'h1,        0);
    vecs[13] = mk(0,   0,   32'h0,        0,   0,   32'h0,        1, 4,  4,  4,   32'hAAAA5555, 0,  32'hAAAA5555, 0,  32'hAAAA5555, 0);
    vecs[14] = mk(0,   0,   32'h0,        1,   4,   32'h55,       1, 4,  4,  0,   32'h55,       0,  32'h0,        0,  32'hAAAA5555, 1);
    vecs[15] = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  4,  4,   32'h55,       1,  32'h55,       1,  32'h55,       1);
    vecs[16] = mk(0,   0,   32'h0,        0,   0,   32'h0,        1, 0,  0,  0,   32'h0,        0,  32'h0,        0,  32'h0,        0);
    vecs[17] = mk(0,   0,   32'h0,        0,   0,   32'h0,        0, 0,  0,  0,   32'h0,        0,  32'h0,        0,  32'h0,        0);
    vecs[18] = mk(0,   0,   32'h0,        1,   0,   32'h77,       0, 0,  0,  9,   32'h0,        0,  32'h1,        0,  32'h0,        0);

    // Outputs while reset is held.
    #2;
    push("rst_rd1", 64'h0); push("rst_rd2", 64'h0);
    push("rst_busy1", 64'h0); push("rst_busy2", 64'h0);
    push("rst_nb_rd2", 64'h0); push("rst_nb_busy2", 64'h0);
    push("rst_w_rd1", 64'h0);
    pop_cmp(rd1); pop_cmp(rd2); pop_cmp(busy1); pop_cmp(busy2);
    pop_cmp(n_rd2); pop_cmp(n_busy2); pop_cmp(w_rd1);
    $display("reset hold: rd1=%h rd2=%h busy1=%b busy2=%b", rd1, rd2, busy1, busy2);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      we_a = vecs[i].we_a; wa_a = vecs[i].wa_a; wd_a = vecs[i].wd_a;
      we_b = vecs[i].we_b; wa_b = vecs[i].wa_b; wd_b = vecs[i].wd_b;
      busy_set = vecs[i].bset; busy_addr = vecs[i].baddr;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      push($sformatf("v%0d_rd1", i), 64'(vecs[i].e_rd1));
      push($sformatf("v%0d_busy1", i), 64'(vecs[i].e_b1));
      push($sformatf("v%0d_rd2", i), 64'(vecs[i].e_rd2));
      push($sformatf("v%0d_busy2", i), 64'(vecs[i].e_b2));
      push($sformatf("v%0d_nb_rd1", i), 64'(vecs[i].n_rd1));
      push($sformatf("v%0d_nb_busy1", i), 64'(vecs[i].n_b1));
      #2;
      pop_cmp(rd1); pop_cmp(busy1); pop_cmp(rd2); pop_cmp(busy2);
      pop_cmp(n_rd1); pop_cmp(n_busy1);
      $display("vec %0d: ra1=%0d ra2=%0d rd1=%h b1=%b rd2=%h b2=%b nb_rd1=%h nb_b1=%b",
               i, ra1, ra2, rd1, busy1, rd2, busy2, n_rd1, n_busy1);
    end

    // Asynchronous reset in the middle of operation.
    @(negedge clk);
    idle32();
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
    busy_set = 1'b1; busy_addr = 5'd5;
    ra1 = 5'd5; ra2 = 5'd9;
    @(negedge clk);
    idle32();
    push("pre_rst_rd1", 64'hDEADBEEF); push("pre_rst_busy1", 64'h1);
    push("pre_rst_nb_rd1", 64'hDEADBEEF);
    #2;
    pop_cmp(rd1); pop_cmp(busy1); pop_cmp(n_rd1);
    $display("pre-reset x5: rd1=%h busy1=%b", rd1, busy1);
    #1 rst_n = 1'b0;
    push("async_rst_rd1", 64'h0); push("async_rst_busy1", 64'h0);
    push("async_rst_nb_rd1", 64'h0); push("async_rst_rd2", 64'h0);
    #1;
    pop_cmp(rd1); pop_cmp(busy1); pop_cmp(n_rd1); pop_cmp(rd2);
    $display("async reset: rd1=%h busy1=%b rd2=%h", rd1, busy1, rd2);
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1;
    @(negedge clk);
    idle32();
    push("rst_held_rd1", 64'h0); push("rst_held_nb_rd1", 64'h0);
    #2;
    pop_cmp(rd1); pop_cmp(n_rd1);
    $display("write during reset: rd1=%h", rd1);
    @(negedge clk);
    rst_n = 1'b1;
    push("post_rst_rd1", 64'h0); push("post_rst_rd2", 64'h0); push("post_rst_busy1", 64'h0);
    #2;
    pop_cmp(rd1); pop_cmp(rd2); pop_cmp(busy1);
    $display("after release: rd1=%h rd2=%h busy1=%b", rd1, rd2, busy1);

    // 64-bit, 16-entry instance with an ordinary register 0.
    @(negedge clk);
    w_we_a = 1'b1; w_wa_a = 4'd0; w_wd_a = 64'hFFFF_FFFF_FFFF_FFFF;
    w_bset = 1'b1; w_baddr = 4'd0; w_ra1 = 4'd0;
    push("w64_byp_x0_rd1", 64'hFFFF_FFFF_FFFF_FFFF); push("w64_byp_x0_busy1", 64'h0);
    #2;
    pop_cmp(w_rd1); pop_cmp(w_busy1);
    $display("w64 write x0: rd1=%h busy1=%b", w_rd1, w_busy1);
    @(negedge clk);
    idle64();
    w_we_a = 1'b1; w_wa_a = 4'd15; w_wd_a = 64'h0123_4567_89AB_CDEF; w_ra2 = 4'd15;
    push("w64_x0_rd1", 64'hFFFF_FFFF_FFFF_FFFF); push("w64_x0_busy1", 64'h1);
    push("w64_byp_x15_rd2", 64'h0123_4567_89AB_CDEF); push("w64_x15_busy2", 64'h0);
    #2;
    pop_cmp(w_rd1); pop_cmp(w_busy1); pop_cmp(w_rd2); pop_cmp(w_busy2);
    $display("w64 write x15: rd1=%h busy1=%b rd2=%h", w_rd1, w_busy1, w_rd2);
    @(negedge clk);
    idle64();
    w_we_b = 1'b1; w_wa_b = 4'd0; w_wd_b = 64'h5;
    push("w64_x15_rd2", 64'h0123_4567_89AB_CDEF);
    push("w64_byp_ldx0_rd1", 64'h5); push("w64_byp_ldx0_busy1", 64'h0);
    #2;
    pop_cmp(w_rd2); pop_cmp(w_rd1); pop_cmp(w_busy1);
    $display("w64 load x0: rd1=%h busy1=%b rd2=%h", w_rd1, w_busy1, w_rd2);
    @(negedge clk);
    idle64();
    push("w64_ldx0_rd1", 64'h5); push("w64_ldx0_busy1", 64'h0);
    #2;
    pop_cmp(w_rd1); pop_cmp(w_busy1);
    $display("w64 after load: rd1=%h busy1=%b", w_rd1, w_busy1);

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp_scoreboard.md
# regfile_mp_scoreboard

Parametrised integer register file for the RISC-V core: two asynchronous read ports, two synchronous write ports (ALU writeback A, load writeback B), optional same-cycle write-to-read bypass, and a per-register busy scoreboard for outstanding loads. It sits between decode (reads, busy checks, load issue) and the two writeback paths. It replaces the fixed 32x32 single-write-port file in the core datapath.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of registers (power of two, 2..64)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: reads see data written in the same cycle
- (derived) AW = clog2(NREGS)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data
- busy1, busy2  out  1  busy bit of ra1 / ra2
- we_a  in  1  write enable, port A (ALU)
- wa_a  in  AW  write address, port A
- wd_a  in  XLEN  write data, port A
- we_b  in  1  write enable, port B (load)
- wa_b  in  AW  write address, port B
- wd_b  in  XLEN  write data, port B
- busy_set  in  1  load issued: mark busy_addr pending
- busy_addr  in  AW  destination of issued load

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits.
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0; held while low.
- Write: on clk rise, we_a writes wd_a to wa_a; we_b writes wd_b to wa_b.
- Write conflict (both enabled, wa_a == wa_b): port A data stored; port B write dropped for the data array but still clears the busy bit.
- ZERO_REG=1: writes to address 0 ignored; rd for address 0 is 0; busy for address 0 is 0; busy_set with busy_addr 0 ignored.
- Read: rdN = array[raN], combinational, no clock.
- BYPASS=1: if raN matches an enabled write address this cycle (and not the zero register), rdN returns the write data (port A over port B on conflict); busyN returns 0 when the matching write is port B, else the stored busy bit. BYPASS=0: rd/busy show pre-edge state only.
- Scoreboard: on clk rise, busy_set sets busy[busy_addr]; we_b clears busy[wa_b]. Port A writes never change busy bits.
- Simultaneous set and clear of the same address: set wins (new load issued after the old one retires); busy stays 1.
- Out-of-range addresses (NREGS not covering AW): not possible, NREGS is a power of two.

## Timing
- Read latency: 0 cycles (combinational from ra, array state and, if BYPASS, write ports).
- Write latency: data visible at non-bypassed read 1 cycle after the enabling edge.
- Busy: set visible the cycle after busy_set; clear visible the cycle after we_b (same cycle if BYPASS).
- Output reset values: rd1 = rd2 = 0, busy1 = busy2 = 0 while rst_n low and after release until first write.
- Reset mid-operation: asserting rst_n during any write aborts it; array and scoreboard return to 0 immediately without waiting for clk.
- No combinational path from busy_set to busy1/busy2.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert rst_n low between edges -> rd1 for ra1=5 is 0 immediately; busy1 = 0.
- Basic write/read, BYPASS=0: we_a, wa_a=7, wd_a=0x12345678 -> rd1 shows old value that cycle, 0x12345678 next cycle; write to x0 with 0xFFFFFFFF -> rd1(ra1=0) stays 0.
- Bypass, BYPASS=1: we_b, wa_b=3, wd_b=0xCAFEF00D, ra2=3 same cycle -> rd2 = 0xCAFEF00D, busy2 = 0 combinationally.
- Write conflict: we_a & we_b both to x9, wd_a=0x1, wd_b=0x2 -> x9 = 0x1 next cycle; busy[9] cleared.
- Scoreboard: busy_set x4 cycle 0 -> busy1(ra1=4) = 1 cycle 1; we_b x4 cycle 3 -> busy1 = 0 cycle 4 (cycle 3 if BYPASS); busy_set and we_b to x4 same edge -> busy stays 1.
- Parameter sweep: XLEN=64, NREGS=16, ZERO_REG=0 -> write 0xFFFF_FFFF_FFFF_FFFF to x0 reads back; write x15 reads back; busy_set x0 sets busy.
